// File: rtl/bcd_count_ctrl.sv
// bcd_count_ctrl: run/pause/clear controller for the two-digit packed-BCD counter
// shown on the seg7 display. Raw buttons are synchronized and debounced, clk_50MHz
// is divided into a count tick, and a three-state FSM gates the up/down count.
module bcd_count_ctrl #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_clear,
    input  logic       up_down,
    output logic [7:0] count,
    output logic       running,
    output logic       wrap
);

    // Debounce counter only has to reach DEB_CYCLES-1; keep at least one bit.
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [PRE_W-1:0] TICK_LAST = PRE_W'(TICK_DIV - 1);

    // Bit positions inside the conditioned input vector.
    localparam int BTN_START = 0;
    localparam int BTN_STOP  = 1;
    localparam int BTN_CLEAR = 2;
    localparam int SW_DIR    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    logic [3:0]       raw_in;
    logic [3:0]       sync1_reg;
    logic [3:0]       sync2_reg;
    logic [2:0]       press;

    state_t           state_reg;
    state_t           state_next;
    logic [PRE_W-1:0] presc_reg;
    logic [PRE_W-1:0] presc_next;
    logic [7:0]       count_reg;
    logic [7:0]       count_next;
    logic             wrap_reg;
    logic             wrap_next;
    logic             running_reg;
    logic             tick;
    logic [3:0]       ones;
    logic [3:0]       tens;

    assign raw_in = {up_down, btn_clear, btn_stop, btn_start};

    // Two-flop synchronizer for every raw asynchronous input.
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= raw_in;
            sync2_reg <= sync1_reg;
        end
    end

    // One debouncer per push-button; the direction switch is only synchronized.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_deb
            logic [DEB_W-1:0] deb_cnt_reg;
            logic             deb_level_reg;
            logic             press_reg;

            // Accept a new level once it has disagreed for DEB_CYCLES cycles; pulse on 0->1.
            always_ff @(posedge clk_50MHz or posedge reset) begin
                if (reset) begin
                    deb_cnt_reg   <= '0;
                    deb_level_reg <= 1'b0;
                    press_reg     <= 1'b0;
                end else begin
                    press_reg <= 1'b0;
                    if (sync2_reg[gi] == deb_level_reg) begin
                        deb_cnt_reg <= '0;
                    end else if (deb_cnt_reg == DEB_LAST) begin
                        deb_cnt_reg   <= '0;
                        deb_level_reg <= sync2_reg[gi];
                        press_reg     <= sync2_reg[gi];
                    end else begin
                        deb_cnt_reg <= deb_cnt_reg + 1'b1;
                    end
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

    assign tick = (state_reg == RUN) && (presc_reg == TICK_LAST);
    assign ones = count_reg[3:0];
    assign tens = count_reg[7:4];

    // Next state, prescaler and BCD step; clear outranks stop, stop outranks start.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        wrap_next  = 1'b0;

        if (press[BTN_CLEAR]) begin
            state_next = IDLE;
        end else if (press[BTN_STOP]) begin
            if (state_reg == RUN) begin
                state_next = PAUSE;
            end
        end else if (press[BTN_START]) begin
            state_next = RUN;
        end

        // A stop landing on a tick still applies the step; a clear wins outright.
        if (press[BTN_CLEAR]) begin
            count_next = 8'h00;
        end else if (tick) begin
            if (sync2_reg[SW_DIR]) begin
                if (ones == 4'd9) begin
                    if (tens == 4'd9) begin
                        count_next = 8'h00;
                        wrap_next  = 1'b1;
                    end else begin
                        count_next = {tens + 4'd1, 4'd0};
                    end
                end else begin
                    count_next = {tens, ones + 4'd1};
                end
            end else begin
                if (ones == 4'd0) begin
                    if (tens == 4'd0) begin
                        count_next = 8'h99;
                        wrap_next  = 1'b1;
                    end else begin
                        count_next = {tens - 4'd1, 4'd9};
                    end
                end else begin
                    count_next = {tens, ones - 4'd1};
                end
            end
        end

        // Prescaler only advances while staying in RUN, so a pause drops the partial interval.
        if ((state_reg == RUN) && (state_next == RUN) && !tick) begin
            presc_next = presc_reg + 1'b1;
        end else begin
            presc_next = '0;
        end
    end

    // State, prescaler and output registers.
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            presc_reg   <= '0;
            count_reg   <= 8'h00;
            wrap_reg    <= 1'b0;
            running_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            presc_reg   <= presc_next;
            count_reg   <= count_next;
            wrap_reg    <= wrap_next;
            running_reg <= (state_next == RUN);
        end
    end

    assign count   = count_reg;
    assign wrap    = wrap_reg;
    assign running = running_reg;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Testbench for bcd_count_ctrl: integer reference model checked every cycle,
// directed scenarios with hand-computed values, then a randomized button phase.
module tb_bcd_count_ctrl;

    localparam int TICK_DIV   = 4;
    localparam int DEB_CYCLES = 3;

    logic       clk_50MHz = 1'b0;
    logic       reset     = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_stop  = 1'b0;
    logic       btn_clear = 1'b0;
    logic       up_down   = 1'b1;
    logic [7:0] count;
    logic       running;
    logic       wrap;

    int checks   = 0;
    int failures = 0;

    bcd_count_ctrl #(
        .TICK_DIV   (TICK_DIV),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .btn_start (btn_start),
        .btn_stop  (btn_stop),
        .btn_clear (btn_clear),
        .up_down   (up_down),
        .count     (count),
        .running   (running),
        .wrap      (wrap)
    );

    always #5 clk_50MHz = ~clk_50MHz;

    // ---------------- reference model (integer count 0..99) ----------------
    int m_mode;          // 0 idle, 1 run, 2 pause
    int m_presc;
    int m_cnt;
    bit m_wrap;
    bit syn1 [4];
    bit syn2 [4];
    bit lvl [3];
    int run_len [3];
    bit pressed [3];

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(n / 10);
        o = 4'(n % 10);
        return {t, o};
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_presc = 0;
        m_cnt   = 0;
        m_wrap  = 0;
        for (int b = 0; b < 4; b++) begin
            syn1[b] = 0;
            syn2[b] = 0;
        end
        for (int b = 0; b < 3; b++) begin
            lvl[b]     = 0;
            run_len[b] = 0;
            pressed[b] = 0;
        end
    endtask

    task automatic model_step();
        bit tick;
        bit ud;
        int nmode;
        bit raw [4];
        bit newp [3];
        raw[0] = btn_start;
        raw[1] = btn_stop;
        raw[2] = btn_clear;
        raw[3] = up_down;
        tick  = (m_mode == 1) && (m_presc == TICK_DIV - 1);
        ud    = syn2[3];
        nmode = m_mode;
        if (pressed[2])      nmode = 0;
        else if (pressed[1]) begin
            if (m_mode == 1) nmode = 2;
        end
        else if (pressed[0]) nmode = 1;

        m_wrap = 0;
        if (pressed[2]) begin
            m_cnt = 0;
        end else if (tick) begin
            if (ud) begin
                m_wrap = (m_cnt == 99);
                m_cnt  = (m_cnt + 1) % 100;
            end else begin
                m_wrap = (m_cnt == 0);
                m_cnt  = (m_cnt + 99) % 100;
            end
        end
        m_presc = (m_mode == 1 && nmode == 1 && !tick) ? m_presc + 1 : 0;
        m_mode  = nmode;

        for (int b = 0; b < 3; b++) begin
            newp[b] = 0;
            if (syn2[b] != lvl[b]) begin
                run_len[b]++;
                if (run_len[b] >= DEB_CYCLES) begin
                    lvl[b]     = syn2[b];
                    run_len[b] = 0;
                    newp[b]    = syn2[b];
                end
            end else begin
                run_len[b] = 0;
            end
            pressed[b] = newp[b];
        end
        for (int b = 0; b < 4; b++) begin
            syn2[b] = syn1[b];
            syn1[b] = raw[b];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_50MHz or posedge reset);
            if (reset) model_reset();
            else       model_step();
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    initial begin
        int prev_cnt;
        logic [7:0] exp_count;
        prev_cnt = 0;
        forever begin
            @(negedge clk_50MHz);
            exp_count = to_bcd(m_cnt);
            checks++;
            if (count !== exp_count) begin
                failures++;
                $display("FAIL model_count t=%0t: got %h, required %h", $time, count, exp_count);
            end
            checks++;
            if (running !== (m_mode == 1)) begin
                failures++;
                $display("FAIL model_running t=%0t: got %b, required %b", $time, running, (m_mode == 1));
            end
            checks++;
            if (wrap !== m_wrap) begin
                failures++;
                $display("FAIL model_wrap t=%0t: got %b, required %b", $time, wrap, m_wrap);
            end
            checks++;
            if (count[3:0] > 4'd9 || count[7:4] > 4'd9) begin
                failures++;
                $display("FAIL legal_bcd t=%0t: got %h, required digits 0..9", $time, count);
            end
            if (m_cnt != prev_cnt)
                $display("step t=%0t count=%h wrap=%b running=%b", $time, count, wrap, running);
            prev_cnt = m_cnt;
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s t=%0t: got %h, required %h", name, $time, act, req);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_50MHz);
    endtask

    task automatic wait_running(input string name, input int limit);
        int n;
        n = 0;
        while (running !== 1'b1 && n < limit) begin
            @(negedge clk_50MHz);
            n++;
        end
        checks++;
        if (running !== 1'b1) begin
            failures++;
            $display("FAIL %s t=%0t: running=%b after %0d cycles, required 1", name, $time, running, limit);
        end
    endtask

    task automatic do_clear();
        btn_clear = 1'b1;
        cycles(8);
        btn_clear = 1'b0;
        cycles(8);
    endtask

    // Start from idle and return at the first cycle running is high.
    task automatic start_run(input string name);
        btn_start = 1'b1;
        wait_running(name, 20);
        btn_start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r;
        int hold;

        cycles(3);
        chk("reset_count", count, 8'h00);
        chk("reset_running", {7'd0, running}, 8'h00);
        chk("reset_wrap", {7'd0, wrap}, 8'h00);
        reset = 1'b0;
        cycles(2);

        // 1: short glitch is rejected, held press starts the count
        btn_start = 1'b1;
        cycles(2);
        btn_start = 1'b0;
        cycles(10);
        chk("glitch_running", {7'd0, running}, 8'h00);
        chk("glitch_count", count, 8'h00);
        start_run("s1_start");
        cycles(3);
        chk("s1_before_step", count, 8'h00);
        cycles(1);
        chk("s1_first_step", count, 8'h01);
        $display("scenario 1 done t=%0t", $time);

        // 2: full up cycle with wrap
        do_clear();
        chk("s2_cleared", count, 8'h00);
        start_run("s2_start");
        cycles(40);
        chk("s2_tick10", count, 8'h10);
        cycles(359);
        chk("s2_tick99", count, 8'h99);
        chk("s2_no_wrap99", {7'd0, wrap}, 8'h00);
        cycles(1);
        chk("s2_wrap_to_00", count, 8'h00);
        chk("s2_wrap_pulse", {7'd0, wrap}, 8'h01);
        cycles(1);
        chk("s2_wrap_done", {7'd0, wrap}, 8'h00);
        $display("scenario 2 done t=%0t", $time);

        // 3: down from 00 with borrow
        up_down = 1'b0;
        do_clear();
        start_run("s3_start");
        cycles(4);
        chk("s3_down_99", count, 8'h99);
        chk("s3_down_wrap", {7'd0, wrap}, 8'h01);
        cycles(1);
        chk("s3_wrap_done", {7'd0, wrap}, 8'h00);
        cycles(3);
        chk("s3_98", count, 8'h98);
        cycles(4);
        chk("s3_97", count, 8'h97);
        cycles(28);
        chk("s3_90", count, 8'h90);
        cycles(4);
        chk("s3_89", count, 8'h89);
        $display("scenario 3 done t=%0t", $time);

        // 4: pause at 42, hold, resume
        up_down = 1'b1;
        do_clear();
        start_run("s4_start");
        cycles(164);
        chk("s4_41", count, 8'h41);
        btn_stop = 1'b1;
        cycles(8);
        btn_stop = 1'b0;
        chk("s4_paused", {7'd0, running}, 8'h00);
        chk("s4_pause_42", count, 8'h42);
        cycles(50);
        chk("s4_hold_42", count, 8'h42);
        start_run("s4_resume");
        cycles(3);
        chk("s4_resume_hold", count, 8'h42);
        cycles(1);
        chk("s4_resume_43", count, 8'h43);
        $display("scenario 4 done t=%0t", $time);

        // 5: clear coinciding with the tick leaving 57
        do_clear();
        start_run("s5_start");
        cycles(226);
        chk("s5_56", count, 8'h56);
        btn_clear = 1'b1;
        cycles(5);
        chk("s5_57", count, 8'h57);
        chk("s5_still_run", {7'd0, running}, 8'h01);
        cycles(1);
        chk("s5_cleared", count, 8'h00);
        chk("s5_no_wrap", {7'd0, wrap}, 8'h00);
        chk("s5_idle", {7'd0, running}, 8'h00);
        cycles(2);
        btn_clear = 1'b0;
        btn_stop  = 1'b1;
        cycles(8);
        btn_stop = 1'b0;
        cycles(8);
        chk("s5_stop_idle_run", {7'd0, running}, 8'h00);
        chk("s5_stop_idle_cnt", count, 8'h00);
        $display("scenario 5 done t=%0t", $time);

        // 6: async reset mid-run
        start_run("s6_start");
        cycles(292);
        chk("s6_73", count, 8'h73);
        #2 reset = 1'b1;
        #1;
        chk("s6_async_count", count, 8'h00);
        chk("s6_async_running", {7'd0, running}, 8'h00);
        chk("s6_async_wrap", {7'd0, wrap}, 8'h00);
        cycles(3);
        reset = 1'b0;
        cycles(20);
        chk("s6_after_rel_cnt", count, 8'h00);
        chk("s6_after_rel_run", {7'd0, running}, 8'h00);
        start_run("s6_restart");
        cycles(4);
        chk("s6_restart_01", count, 8'h01);
        $display("scenario 6 done t=%0t", $time);

        // randomized buttons, direction and occasional resets
        for (int seg = 0; seg < 250; seg++) begin
            r         = $urandom_range(0, 99);
            btn_start = (r < 40);
            btn_stop  = (r >= 40 && r < 65);
            btn_clear = (r >= 65 && r < 75);
            up_down   = 1'($urandom_range(0, 1));
            hold      = $urandom_range(1, 30);
            if (seg % 60 == 59) begin
                #2 reset = 1'b1;
                @(negedge clk_50MHz);
                reset = 1'b0;
            end
            cycles(hold);
        end
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        btn_clear = 1'b0;
        cycles(10);
        $display("random phase done t=%0t", $time);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
